// File: rtl/nor_test_sequencer.sv
// Sequences the four input vectors into a 2-input NOR gate, waits a settle time per
// vector, checks the gate output and reports error count, first failing vector and verdict.
module nor_test_sequencer #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned LOOPS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       vout,
    output logic       vin1,
    output logic       vin2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] first_fail
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned IDX_W = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] loop_q, loop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] ff_q, ff_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             mismatch_c;

    // Gate output differs from the NOR of the vector currently driven.
    assign mismatch_c = (vout != ~(idx_q[0] | idx_q[1]));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    loop_d  = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                cnt_d = '0;
                if (mismatch_c) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (err_q == '0) begin
                        ff_d = idx_q;
                    end
                end
                if (idx_q != {IDX_W{1'b1}}) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SETTLE;
                end else if (loop_q != CNT_W'(LOOPS - 1)) begin
                    idx_d   = '0;
                    loop_d  = loop_q + CNT_W'(1);
                    state_d = ST_SETTLE;
                end else begin
                    // Verdict includes a mismatch found in this final check.
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            loop_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // The vector index only moves on SETTLE entry edges, so vin follows it directly.
    assign vin1       = idx_q[0];
    assign vin2       = idx_q[1];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_nor_test_sequencer.sv
// Bench for nor_test_sequencer: three parameterisations against a timeline-based model,
// directed scenarios with literal expectations, then randomized start/reset/gate faults.
module tb_nor_test_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] vout_v, vin1_v, vin2_v, busy_v, done_v, pass_v;
    logic [7:0] err_v [3];
    logic [1:0] ff_v  [3];

    int  mode [3];   // 0 good NOR, 1 stuck-0, 2 stuck-1, 3 OR gate, 4 random
    bit  rnd  [3];
    int  n_total = 0;
    int  n_bad   = 0;
    bit  chk_on  = 1'b0;
    int  done_at [3];

    // Model state: cycles since the accept edge, running error tally, verdict, vector
    bit  m_act  [3];
    int  m_t    [3];
    int  m_err  [3];
    int  m_ff   [3];
    bit  m_pass [3];
    int  m_vec  [3];

    always #5 clk = ~clk;

    nor_test_sequencer #(.SETTLE(2), .LOOPS(1)) u0 (
        .clk(clk), .rst(rst), .start(start), .vout(vout_v[0]),
        .vin1(vin1_v[0]), .vin2(vin2_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_count(err_v[0]), .first_fail(ff_v[0]));

    nor_test_sequencer #(.SETTLE(2), .LOOPS(3)) u1 (
        .clk(clk), .rst(rst), .start(start), .vout(vout_v[1]),
        .vin1(vin1_v[1]), .vin2(vin2_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_count(err_v[1]), .first_fail(ff_v[1]));

    nor_test_sequencer #(.SETTLE(1), .LOOPS(1)) u2 (
        .clk(clk), .rst(rst), .start(start), .vout(vout_v[2]),
        .vin1(vin1_v[2]), .vin2(vin2_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_count(err_v[2]), .first_fail(ff_v[2]));

    function automatic logic gate_f(input int m, input logic a, input logic b, input logic r);
        case (m)
            0:       return ~(a | b);
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return a | b;
            default: return r;
        endcase
    endfunction

    function automatic int s_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int l_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    always_comb begin
        vout_v = '0;
        for (int i = 0; i < 3; i++) begin
            vout_v[i] = gate_f(mode[i], vin1_v[i], vin2_v[i], rnd[i]);
        end
    end

    // Reference: a run is a timeline of 4*LOOPS vectors of SETTLE+1 cycles, then one DONE cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int sp;
            int n;
            int v;
            logic [1:0] vb;
            sp = s_of(i) + 1;
            n  = 4 * l_of(i) * sp;
            if (rst) begin
                m_act[i] = 1'b0; m_t[i] = 0; m_err[i] = 0; m_ff[i] = 0;
                m_pass[i] = 1'b0; m_vec[i] = 0;
            end else if (!m_act[i]) begin
                if (start) begin
                    m_act[i] = 1'b1; m_t[i] = 0; m_err[i] = 0; m_ff[i] = 0;
                    m_pass[i] = 1'b0; m_vec[i] = 0;
                end
            end else if (m_t[i] == n) begin
                m_act[i] = 1'b0;
            end else begin
                if (m_t[i] % sp == sp - 1) begin
                    v  = (m_t[i] / sp) % 4;
                    vb = 2'(v);
                    if (gate_f(mode[i], vb[0], vb[1], rnd[i]) != (v == 0)) begin
                        if (m_err[i] == 0) m_ff[i] = v;
                        if (m_err[i] < 255) m_err[i] = m_err[i] + 1;
                    end
                end
                m_t[i] = m_t[i] + 1;
                if (m_t[i] == n) m_pass[i] = (m_err[i] == 0);
                else             m_vec[i]  = (m_t[i] / sp) % 4;
            end
        end
    end

    // Cycle-by-cycle comparison of every output of every instance against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                logic [14:0] got;
                logic [14:0] want;
                int n;
                n    = 4 * l_of(i) * (s_of(i) + 1);
                got  = {busy_v[i], done_v[i], pass_v[i], err_v[i], ff_v[i], vin2_v[i], vin1_v[i]};
                want = {m_act[i], (m_act[i] && m_t[i] == n), m_pass[i], 8'(m_err[i]),
                        2'(m_ff[i]), 2'(m_vec[i])};
                n_total++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL model inst%0d t=%0t got={busy,done,pass,err,ff,vin}=%h want=%h",
                             i, $time, got, want);
                end
            end
        end
    end

    task automatic check_eq(input string name, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Records, per instance, the number of edges after the accept edge until done is seen.
    task automatic run_all(input int repulse_at);
        for (int i = 0; i < 3; i++) done_at[i] = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = (c == repulse_at);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i] && done_at[i] == 0) done_at[i] = c;
            end
            if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin mode[i] = 0; rnd[i] = 1'b0; end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        check_eq("reset_busy", int'(busy_v), 0);
        check_eq("reset_err0", int'(err_v[0]), 0);
        check_eq("reset_pass", int'(pass_v), 0);

        // Good gate on all three parameterisations.
        pulse_start();
        run_all(0);
        check_eq("good_done_cyc_s2l1", done_at[0], 12);
        check_eq("good_done_cyc_s2l3", done_at[1], 36);
        check_eq("good_done_cyc_s1l1", done_at[2], 8);
        check_eq("good_pass0", int'(pass_v[0]), 1);
        check_eq("good_err0", int'(err_v[0]), 0);
        check_eq("good_pass2", int'(pass_v[2]), 1);

        // Stuck-at-0 output: only vector 0 fails; a new start clears the previous verdict.
        for (int i = 0; i < 3; i++) mode[i] = 1;
        pulse_start();
        check_eq("restart_clears_pass", int'(pass_v[0]), 0);
        check_eq("restart_busy", int'(busy_v[0]), 1);
        run_all(0);
        check_eq("stuck0_err", int'(err_v[0]), 1);
        check_eq("stuck0_ff", int'(ff_v[0]), 0);
        check_eq("stuck0_pass", int'(pass_v[0]), 0);
        check_eq("stuck0_err_l3", int'(err_v[1]), 3);

        // OR gate: every vector fails on every loop.
        for (int i = 0; i < 3; i++) mode[i] = 3;
        pulse_start();
        run_all(0);
        check_eq("or_err_l3", int'(err_v[1]), 12);
        check_eq("or_ff_l3", int'(ff_v[1]), 0);
        check_eq("or_pass_l3", int'(pass_v[1]), 0);
        check_eq("or_done_cyc_l3", done_at[1], 36);

        // start re-pulsed mid-run is ignored.
        for (int i = 0; i < 3; i++) mode[i] = 0;
        pulse_start();
        run_all(5);
        check_eq("repulse_done_cyc", done_at[0], 12);
        check_eq("repulse_done_cyc_s1", done_at[2], 8);
        check_eq("repulse_pass", int'(pass_v[0]), 1);

        // Reset during SETTLE of vector 2 aborts without a done pulse.
        pulse_start();
        repeat (6) @(negedge clk);
        check_eq("abort_vin2", int'(vin2_v[0]), 1);
        check_eq("abort_vin1", int'(vin1_v[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", int'(busy_v), 0);
        check_eq("abort_vin", int'({vin2_v, vin1_v}), 0);
        check_eq("abort_pass", int'(pass_v), 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_v != '0) pulses++;
        end
        check_eq("abort_no_done", pulses, 0);
        pulse_start();
        run_all(0);
        check_eq("after_abort_done_cyc", done_at[0], 12);
        check_eq("after_abort_pass", int'(pass_v[0]), 1);

        // Randomized start, reset and gate behaviour.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++) rnd[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) mode[$urandom_range(0, 2)] = int'($urandom_range(0, 4));
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/nor_test_sequencer.md
NOR_TEST_SEQUENCER -- requirements
Module: nor_test_sequencer

Interface
REQ-001 Parameter SETTLE, default 2: number of clock cycles each input vector is held before the output is sampled; legal range 1..15.
REQ-002 Parameter LOOPS, default 1: number of full passes over the four input vectors per run; legal range 1..15.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port start, input, 1: run request, sampled only in IDLE.
REQ-006 Port vout, input, 1: output of the 2-input NOR gate under test.
REQ-007 Port vin1, output, 1: gate input 1, registered.
REQ-008 Port vin2, output, 1: gate input 2, registered.
REQ-009 Port busy, output, 1: high in every state except IDLE.
REQ-010 Port done, output, 1: one-cycle pulse marking the end of a run.
REQ-011 Port pass, output, 1: run verdict, valid from done onward.
REQ-012 Port err_count, output, 8: number of mismatches in the current or last run.
REQ-013 Port first_fail, output, 2: vector index {vin2,vin1} of the first mismatch in the run.

Function
REQ-014 The FSM SHALL have four states: IDLE, SETTLE, CHECK, DONE.
REQ-015 Vector index idx (2 bits) SHALL drive vin1=idx[0] and vin2=idx[1]; vectors run in order 0,1,2,3, so vin1 toggles fastest.
REQ-016 In IDLE with start=1, the next edge SHALL: clear idx, the loop counter, err_count, first_fail and pass; drive vin1=vin2=0; load settle counter=0; and enter SETTLE.
REQ-017 In IDLE, start=0 SHALL leave all outputs unchanged, so results from the previous run are held.
REQ-018 SETTLE SHALL last exactly SETTLE cycles, then move to CHECK.
REQ-019 CHECK SHALL last one cycle and compare vout to expected = ~(vin1|vin2), using the vin values currently driven.
REQ-020 On a mismatch in CHECK: err_count SHALL increment, saturating at 255; when err_count was 0, first_fail SHALL be set to idx.
REQ-021 Leaving CHECK when idx<3: idx SHALL increment, vin SHALL update on the same edge, and the FSM SHALL re-enter SETTLE with the counter cleared.
REQ-022 Leaving CHECK when idx=3 and the loop counter < LOOPS-1: idx SHALL wrap to 0, the loop counter SHALL increment, and the FSM SHALL enter SETTLE.
REQ-023 Leaving CHECK when idx=3 and the loop counter = LOOPS-1: the FSM SHALL enter DONE.
REQ-024 In DONE: done=1 and pass=(err_count==0) for one cycle; the next state is IDLE; pass stays registered until the next start.
REQ-025 Each vector SHALL take SETTLE+1 cycles, so a run takes 4*LOOPS*(SETTLE+1) cycles from the start-accept edge to the DONE entry edge.
REQ-026 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 A mismatch detected in the last CHECK of a run SHALL be included in err_count and pass in the immediately following DONE cycle.
REQ-028 vin1 and vin2 SHALL change only on SETTLE entry edges, never during SETTLE or CHECK.

Reset
REQ-029 With rst=1, the next edge SHALL force: state=IDLE, vin1=0, vin2=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, and all internal counters to 0.
REQ-030 rst SHALL take priority over start and over any in-progress run; a run aborted by reset SHALL NOT produce done.

Verification
REQ-031 Good NOR, SETTLE=2, LOOPS=1, start pulsed -> done exactly 12 cycles after the accept edge; pass=1, err_count=0; vin sequence 00,01,10,11 in {vin2,vin1} order, each held 3 cycles.
REQ-032 vout tied to 0 -> vector 0 fails only; err_count=1, first_fail=0, pass=0.
REQ-033 vout = vin1|vin2 (OR model), LOOPS=3 -> err_count=12, first_fail=0, pass=0, done after 36 cycles.
REQ-034 start re-pulsed mid-run -> ignored; done still at cycle 12; a second start in IDLE clears err_count and pass.
REQ-035 rst asserted during SETTLE of vector 2 -> next edge IDLE with all outputs 0; no done pulse; a fresh start then completes normally.
REQ-036 SETTLE=1 boundary -> 8-cycle run; each vector held 2 cycles; pass=1 with a good gate.
